code_entry_ctrl: RTL and testbench
==================================

// Module: code_entry_ctrl
// PURPOSE
//  Sequencer for the keypad-lock datapath. Consumes the 5-bit keypad encoder word {valid, BCD digit},
//  collects DIGITS key presses into an entry buffer and compares the buffer with the stored code.
//  On a match it drives a timed unlock. While unlocked it can program a new code.
//  Replaces ripple-clocked slot sequencing with a single-clock FSM.
// PARAMETERS
//  DIGITS        3        digits per code (>=1)
//  DEFAULT_CODE  12'h123  reset code, 4*DIGITS bits; first-entered digit in MSB nibble
//  UNLOCK_CYCLES 16       cycles unlock stays high (>=1)
//  MAX_FAIL      3        consecutive mismatches before lockout (LOCKOUT_EN only)
//  LOCK_CYCLES   64       lockout duration in cycles (LOCKOUT_EN only)
// PORTS
//  clk        in   1                       single clock, all logic on posedge
//  rst        in   1                       synchronous, active-high reset
//  key_in     in   5                       [4]=key valid, [3:0]=BCD digit (from keypad encoder)
//  mode_sel   in   1                       0=enter/unlock, 1=program (honoured only in OPEN)
//  clear      in   1                       abort current entry, level-sampled
//  digit_idx  out  $clog2(DIGITS+1)        digits collected so far
//  unlock     out  1                       lock open
//  error      out  1                       1-cycle pulse on code mismatch
//  code_set   out  1                       1-cycle pulse when a new code is committed
//  locked_out out  1                       lockout active (tied 0 without LOCKOUT_EN)
// BEHAVIOUR
//  - Outputs are registered. On rst: state=IDLE, code_reg=DEFAULT_CODE, buffer=0, digit_idx=0, and all
//    flag outputs are 0. key_prev resets to 1, so a key held through reset is accepted only after release.
//  - Key accept: on an edge with key_in[4]=1 and key_prev=0. A held key counts once.
//    A digit >9 with valid high is ignored; it does not advance the index.
//  - Priority: rst > clear > key accept. clear returns COLLECT/PROG to IDLE.
//    clear zeros the buffer and digit_idx and leaves code_reg unchanged.
//  - IDLE: accepted digit -> buf[0], digit_idx=1, go to COLLECT (CHECK if DIGITS==1).
//  - COLLECT: accepted digit -> buf[digit_idx], digit_idx++. The last digit goes to CHECK.
//  - CHECK: one cycle; buffer compared to code_reg; digit_idx cleared.
//    match -> OPEN; unlock rises on the next edge and stays high exactly UNLOCK_CYCLES cycles; fail_cnt=0.
//    mismatch -> IDLE; error high for 1 cycle on the next edge; fail_cnt++.
//  - Latency: last digit accepted at edge k -> CHECK after edge k -> unlock/error visible after edge k+1.
//  - OPEN: timer counts down from UNLOCK_CYCLES-1 and goes to IDLE at 0 (unlock falls on the same edge).
//    A digit with mode_sel=0 is ignored. A digit with mode_sel=1 goes to PROG: buf[0] is stored, unlock
//    drops, the timer stops.
//  - PROG: collect as in COLLECT. On the last digit, code_reg <= buffer, code_set pulses 1 cycle, go to IDLE.
//  - Keys arriving in CHECK are ignored, but key_prev still tracks key_in.
//  - digit_idx never exceeds DIGITS; the index wraps to 0 on every return to IDLE.
// CONFIGURATION
//  - CODE_ENTRY_LOCKOUT_EN defined: when fail_cnt reaches MAX_FAIL, CHECK goes to LOCK instead of IDLE
//    (error still pulses). LOCK holds locked_out=1 for LOCK_CYCLES cycles and ignores keys and clear.
//    LOCK then goes to IDLE with fail_cnt=0.
//  - Undefined: no LOCK state or counter; locked_out is tied 0; mismatches always return to IDLE.
// STRUCTURE
//  - Package code_entry_pkg: DIGIT_W=4, KEY_VALID_BIT=4, MAX_DIGIT=9,
//    state typedef {IDLE, COLLECT, CHECK, OPEN, PROG, LOCK}.
//  - Sub-module key_edge_detect: registers key_in, outputs accept pulse + digit, owns key_prev reset-to-1.
//  - Top holds the FSM, entry buffer, code_reg, unlock timer and fail counter.
// TESTING (DIGITS=3, DEFAULT_CODE=12'h123, UNLOCK_CYCLES=16, MAX_FAIL=3, LOCK_CYCLES=64)
//  - Press 1,2,3 (each 1-4 cycles high, gaps between) -> unlock high exactly 16 cycles starting 1 cycle after CHECK; error stays 0.
//  - Press 1,2,4 -> error 1-cycle pulse, unlock stays 0, digit_idx back to 0.
//  - Unlock, then mode_sel=1 and press 9,8,7 -> code_set pulse; 1,2,3 then fails and 9,8,7 unlocks.
//  - Press 1,2 then clear with a simultaneous key press -> digit_idx=0, no CHECK; then 1,2,3 unlocks.
//  - Hold key 5 across rst release, plus key_in=5'b11111 -> no digit accepted for either; digit_idx=0.
//  - With LOCKOUT_EN: 3 wrong codes -> locked_out high 64 cycles; a correct code during lockout is
//    ignored; the correct code after lockout unlocks.

Source files
------------

// File: rtl/code_entry_pkg.sv
// Shared constants and state type for the keypad-lock code entry sequencer.
// The optional lockout feature is enabled by defining CODE_ENTRY_LOCKOUT_EN.
package code_entry_pkg;

   localparam int unsigned DIGIT_W       = 4;
   localparam int unsigned KEY_VALID_BIT = 4;
   localparam int unsigned KEY_W         = KEY_VALID_BIT + 1;
   localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StCheck,
      StOpen,
      StProg,
      StLock
   } state_e;

   function automatic logic digit_is_bcd(input logic [DIGIT_W-1:0] d);
      return d <= MAX_DIGIT;
   endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns the keypad encoder word into a one-cycle accept strobe on the rising edge of key valid.
// key_prev resets to 1 so a key already held when reset releases is not taken as a press.
module key_edge_detect
   import code_entry_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [KEY_W-1:0]   key_in,
   output logic               accept,
   output logic [DIGIT_W-1:0] digit
);

   logic key_prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         key_prev_q <= 1'b1;
      end else begin
         key_prev_q <= key_in[KEY_VALID_BIT];
      end
   end

   assign digit  = key_in[DIGIT_W-1:0];
   // Non-BCD codes still consume the valid edge, so they can never be accepted later while held.
   assign accept = key_in[KEY_VALID_BIT] & ~key_prev_q & digit_is_bcd(digit);

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad-lock sequencer: collects digits, checks them against the stored code, drives a timed
// unlock and reprograms the code while open. Define CODE_ENTRY_LOCKOUT_EN for failed-attempt lockout.
module code_entry_ctrl
   import code_entry_pkg::*;
#(
   parameter int unsigned                 DIGITS        = 3,
   parameter logic [DIGIT_W*DIGITS-1:0]   DEFAULT_CODE  = 12'h123,
   parameter int unsigned                 UNLOCK_CYCLES = 16,
   parameter int unsigned                 MAX_FAIL      = 3,
   parameter int unsigned                 LOCK_CYCLES   = 64
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [KEY_W-1:0]              key_in,
   input  logic                          mode_sel,
   input  logic                          clear,
   output logic [$clog2(DIGITS+1)-1:0]   digit_idx,
   output logic                          unlock,
   output logic                          error,
   output logic                          code_set,
   output logic                          locked_out
);

   localparam int unsigned CODE_W = DIGIT_W * DIGITS;
   localparam int unsigned IDX_W  = $clog2(DIGITS + 1);
   localparam int unsigned UT_W   = $clog2(UNLOCK_CYCLES + 1);

   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DIGITS - 1);
   localparam logic [UT_W-1:0]  UNLOCK_LOAD = UT_W'(UNLOCK_CYCLES - 1);

   if (DIGITS < 1 || UNLOCK_CYCLES < 1 || MAX_FAIL < 1 || LOCK_CYCLES < 1) begin : g_bad_params
      $error("code_entry_ctrl: DIGITS, UNLOCK_CYCLES, MAX_FAIL and LOCK_CYCLES must be >= 1");
   end

   logic               accept;
   logic [DIGIT_W-1:0] digit;

   state_e             state_q;
   logic [CODE_W-1:0]  buf_q;
   logic [CODE_W-1:0]  code_q;
   logic [IDX_W-1:0]   idx_q;
   logic [UT_W-1:0]    utimer_q;
   logic               unlock_q;
   logic               error_q;
   logic               code_set_q;

   logic [CODE_W-1:0]  buf_shift;
   logic [IDX_W-1:0]   idx_inc;
   logic               is_last;

`ifdef CODE_ENTRY_LOCKOUT_EN
   localparam int unsigned FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int unsigned LT_W   = $clog2(LOCK_CYCLES + 1);

   localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
   localparam logic [LT_W-1:0]   LOCK_LOAD = LT_W'(LOCK_CYCLES - 1);

   logic [FAIL_W-1:0] fail_q;
   logic [LT_W-1:0]   ltimer_q;
   logic              locked_q;
`endif

   key_edge_detect u_key_edge_detect (
      .clk    (clk),
      .rst    (rst),
      .key_in (key_in),
      .accept (accept),
      .digit  (digit)
   );

   // The buffer is kept zero outside an entry, so shifting the new digit in from the right leaves
   // the first-entered digit in the top nibble once all DIGITS are in, matching the code layout.
   assign buf_shift = (buf_q << DIGIT_W) | CODE_W'(digit);
   assign idx_inc   = idx_q + IDX_W'(1);
   assign is_last   = (idx_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         buf_q      <= '0;
         code_q     <= DEFAULT_CODE;
         idx_q      <= '0;
         utimer_q   <= '0;
         unlock_q   <= 1'b0;
         error_q    <= 1'b0;
         code_set_q <= 1'b0;
`ifdef CODE_ENTRY_LOCKOUT_EN
         fail_q     <= '0;
         ltimer_q   <= '0;
         locked_q   <= 1'b0;
`endif
      end else begin
         error_q    <= 1'b0;
         code_set_q <= 1'b0;

         unique case (state_q)
            StIdle, StCollect, StProg: begin
               if (clear) begin
                  state_q <= StIdle;
                  buf_q   <= '0;
                  idx_q   <= '0;
               end else if (accept) begin
                  if (!is_last) begin
                     buf_q <= buf_shift;
                     idx_q <= idx_inc;
                     if (state_q == StIdle) begin
                        state_q <= StCollect;
                     end
                  end else if (state_q == StProg) begin
                     code_q     <= buf_shift;
                     code_set_q <= 1'b1;
                     buf_q      <= '0;
                     idx_q      <= '0;
                     state_q    <= StIdle;
                  end else begin
                     buf_q   <= buf_shift;
                     idx_q   <= idx_inc;
                     state_q <= StCheck;
                  end
               end
            end

            StCheck: begin
               buf_q <= '0;
               idx_q <= '0;
               if (buf_q == code_q) begin
                  state_q  <= StOpen;
                  unlock_q <= 1'b1;
                  utimer_q <= UNLOCK_LOAD;
`ifdef CODE_ENTRY_LOCKOUT_EN
                  fail_q   <= '0;
`endif
               end else begin
                  error_q <= 1'b1;
`ifdef CODE_ENTRY_LOCKOUT_EN
                  fail_q  <= fail_q + FAIL_W'(1);
                  if (fail_q >= FAIL_LAST) begin
                     state_q  <= StLock;
                     locked_q <= 1'b1;
                     ltimer_q <= LOCK_LOAD;
                  end else begin
                     state_q <= StIdle;
                  end
`else
                  state_q <= StIdle;
`endif
               end
            end

            StOpen: begin
               // Only a program-mode key leaves OPEN early; it stops the unlock timer.
               if (accept && !clear && mode_sel) begin
                  unlock_q <= 1'b0;
                  if (is_last) begin
                     code_q     <= buf_shift;
                     code_set_q <= 1'b1;
                     buf_q      <= '0;
                     idx_q      <= '0;
                     state_q    <= StIdle;
                  end else begin
                     buf_q   <= buf_shift;
                     idx_q   <= idx_inc;
                     state_q <= StProg;
                  end
               end else if (utimer_q == '0) begin
                  unlock_q <= 1'b0;
                  state_q  <= StIdle;
               end else begin
                  utimer_q <= utimer_q - UT_W'(1);
               end
            end

            StLock: begin
`ifdef CODE_ENTRY_LOCKOUT_EN
               if (ltimer_q == '0) begin
                  locked_q <= 1'b0;
                  fail_q   <= '0;
                  state_q  <= StIdle;
               end else begin
                  ltimer_q <= ltimer_q - LT_W'(1);
               end
`else
               state_q <= StIdle;
`endif
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign digit_idx = idx_q;
   assign unlock    = unlock_q;
   assign error     = error_q;
   assign code_set  = code_set_q;
`ifdef CODE_ENTRY_LOCKOUT_EN
   assign locked_out = locked_q;
`else
   assign locked_out = 1'b0;
`endif

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Self-checking bench for code_entry_ctrl: randomized key timing and codes against an
// attempt-level model of the lock. Honours CODE_ENTRY_LOCKOUT_EN like the design.
module tb_code_entry_ctrl;

   localparam int unsigned DIGITS        = 3;
   localparam int unsigned UNLOCK_CYCLES = 16;
   localparam int unsigned MAX_FAIL      = 3;
   localparam int unsigned LOCK_CYCLES   = 64;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] key_in = 5'b0;
   logic       mode_sel = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] digit_idx;
   logic       unlock;
   logic       error;
   logic       code_set;
   logic       locked_out;

   code_entry_ctrl #(
      .DIGITS        (DIGITS),
      .DEFAULT_CODE  (12'h123),
      .UNLOCK_CYCLES (UNLOCK_CYCLES),
      .MAX_FAIL      (MAX_FAIL),
      .LOCK_CYCLES   (LOCK_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in),
      .mode_sel   (mode_sel),
      .clear      (clear),
      .digit_idx  (digit_idx),
      .unlock     (unlock),
      .error      (error),
      .code_set   (code_set),
      .locked_out (locked_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Observation counters, accumulated at every falling edge.
   int cyc = 0;
   int unlock_n, error_n, cs_n, locked_n, lock_total;
   int first_unlock, last_error, last_cs, press_cyc;
   logic [1:0] idx_after [3];

   // Reference model: stored code (first-entered digit first) and consecutive-failure streak.
   int code_m [3];
   int streak;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      if (unlock === 1'b1) begin
         if (first_unlock < 0) first_unlock = cyc;
         unlock_n++;
      end
      if (error === 1'b1) begin
         error_n++;
         last_error = cyc;
      end
      if (code_set === 1'b1) begin
         cs_n++;
         last_cs = cyc;
      end
      if (locked_out === 1'b1) begin
         locked_n++;
         lock_total++;
      end
   endtask

   task automatic clear_obs();
      unlock_n = 0;
      error_n = 0;
      cs_n = 0;
      locked_n = 0;
      first_unlock = -1;
      last_error = -1;
      last_cs = -1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      key_in = 5'b0;
      mode_sel = 1'b0;
      clear = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      code_m = '{1, 2, 3};
      streak = 0;
   endtask

   // Press three digits with random hold and gap lengths; idx_after[i] is digit_idx one cycle
   // after key i first goes valid, press_cyc is the cycle the last key was driven.
   task automatic enter(input int d0, input int d1, input int d2, input bit prog,
                        input int settle);
      int ds [3];
      int hold;
      int gap;
      ds = '{d0, d1, d2};
      clear_obs();
      mode_sel = prog;
      for (int i = 0; i < 3; i++) begin
         hold = $urandom_range(1, 4);
         gap = $urandom_range(1, 3);
         key_in = {1'b1, 4'(ds[i])};
         press_cyc = cyc;
         tick();
         idx_after[i] = digit_idx;
         repeat (hold - 1) tick();
         key_in = 5'b0;
         repeat (gap) tick();
      end
      mode_sel = 1'b0;
      repeat (settle) tick();
   endtask

   // An unlock-mode attempt from IDLE, checked against the model's predicted outcome.
   task automatic attempt(input int d0, input int d1, input int d2, input bit short_open);
      bit match;
      bit lock_now;
      int settle;
      match = (d0 == code_m[0]) && (d1 == code_m[1]) && (d2 == code_m[2]);
      lock_now = 1'b0;
      if (match) begin
         streak = 0;
      end else begin
         streak++;
`ifdef CODE_ENTRY_LOCKOUT_EN
         if (streak >= MAX_FAIL) begin
            lock_now = 1'b1;
            streak = 0;
         end
`endif
      end
      settle = lock_now ? LOCK_CYCLES + 8 : ((match && short_open) ? 0 : 24);
      enter(d0, d1, d2, 1'b0, settle);
      chk("idx_in_check", 32'(idx_after[2]), DIGITS);
      if (match) begin
         chk("unlock_latency", first_unlock - press_cyc, 2);
         if (!short_open) chk("unlock_cycles", unlock_n, UNLOCK_CYCLES);
         chk("error_on_match", error_n, 0);
      end else begin
         chk("error_pulse_cycles", error_n, 1);
         chk("error_latency", last_error - press_cyc, 2);
         chk("unlock_on_mismatch", unlock_n, 0);
      end
      chk("locked_cycles", locked_n, lock_now ? LOCK_CYCLES : 0);
      if (!(match && short_open)) chk("idx_after_attempt", 32'(digit_idx), 0);
   endtask

   // Program a new code; the lock must currently be open.
   task automatic program_code(input int d0, input int d1, input int d2);
      enter(d0, d1, d2, 1'b1, 24);
      chk("prog_idx_first", 32'(idx_after[0]), 1);
      chk("prog_idx_second", 32'(idx_after[1]), 2);
      chk("prog_idx_commit", 32'(idx_after[2]), 0);
      chk("code_set_pulses", cs_n, 1);
      chk("code_set_latency", last_cs - press_cyc, 1);
      chk("unlock_during_prog", unlock_n, 0);
      chk("error_during_prog", error_n, 0);
      code_m = '{d0, d1, d2};
   endtask

   initial begin
      int r;
      int a, b, c;

      code_m = '{1, 2, 3};
      streak = 0;
      clear_obs();
      lock_total = 0;

      // Reset state.
      tick();
      chk("rst_digit_idx", 32'(digit_idx), 0);
      chk("rst_unlock", 32'(unlock), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_code_set", 32'(code_set), 0);
      chk("rst_locked_out", 32'(locked_out), 0);

      // Key held through reset release, then a non-BCD key: neither is accepted.
      key_in = {1'b1, 4'd5};
      repeat (2) tick();
      rst = 1'b0;
      repeat (4) tick();
      chk("held_key_idx", 32'(digit_idx), 0);
      key_in = 5'b0;
      repeat (2) tick();
      key_in = 5'b11111;
      repeat (3) tick();
      chk("non_bcd_idx", 32'(digit_idx), 0);
      key_in = 5'b0;
      tick();

      // Default code opens, a wrong code errors.
      attempt(1, 2, 3, 1'b0);
      chk("idx_first_digit", 32'(idx_after[0]), 1);
      chk("idx_second_digit", 32'(idx_after[1]), 2);
      attempt(1, 2, 4, 1'b0);

      // Open, program 9,8,7, then only the new code opens.
      attempt(1, 2, 3, 1'b1);
      program_code(9, 8, 7);
      attempt(1, 2, 3, 1'b0);
      attempt(9, 8, 7, 1'b0);

      // clear together with a key press aborts the partial entry.
      clear_obs();
      key_in = {1'b1, 4'(code_m[0])};
      tick();
      key_in = 5'b0;
      tick();
      key_in = {1'b1, 4'(code_m[1])};
      tick();
      key_in = 5'b0;
      tick();
      chk("idx_before_clear", 32'(digit_idx), 2);
      clear = 1'b1;
      key_in = {1'b1, 4'(code_m[2])};
      tick();
      chk("idx_after_clear", 32'(digit_idx), 0);
      clear = 1'b0;
      key_in = 5'b0;
      repeat (24) tick();
      chk("clear_no_error", error_n, 0);
      chk("clear_no_unlock", unlock_n, 0);
      attempt(code_m[0], code_m[1], code_m[2], 1'b0);

      // Randomized mix of correct, wrong and reprogramming attempts.
      for (int it = 0; it < 10; it++) begin
         r = $urandom_range(0, 3);
         if (r == 0) begin
            attempt(code_m[0], code_m[1], code_m[2], 1'b1);
            a = $urandom_range(0, 9);
            b = $urandom_range(0, 9);
            c = $urandom_range(0, 9);
            program_code(a, b, c);
         end else if (r == 1) begin
            attempt(code_m[0], code_m[1], code_m[2], 1'b0);
         end else begin
            a = $urandom_range(0, 9);
            b = $urandom_range(0, 9);
            c = $urandom_range(0, 9);
            attempt(a, b, c, 1'b0);
         end
      end

      // Consecutive failures from a fresh reset.
      do_reset();
`ifdef CODE_ENTRY_LOCKOUT_EN
      attempt(4, 4, 4, 1'b0);
      attempt(5, 5, 5, 1'b0);
      lock_total = 0;
      enter(6, 6, 6, 1'b0, 4);
      chk("lockout_error", error_n, 1);
      chk("lockout_active", 32'(locked_out), 1);
      enter(1, 2, 3, 1'b0, 4);
      chk("lockout_ignores_unlock", unlock_n, 0);
      chk("lockout_ignores_idx", 32'(idx_after[2]), 0);
      for (int i = 0; i < 200 && locked_out === 1'b1; i++) tick();
      chk("lockout_released", 32'(locked_out), 0);
      chk("lockout_duration", lock_total, LOCK_CYCLES);
      streak = 0;
      attempt(1, 2, 3, 1'b0);
`else
      attempt(4, 4, 4, 1'b0);
      attempt(5, 5, 5, 1'b0);
      attempt(6, 6, 6, 1'b0);
      chk("no_lockout_flag", 32'(locked_out), 0);
      attempt(1, 2, 3, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

endmodule
